// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the 16-bit reduced-ARM core.
// Optional retired-instruction counter is built only when CPU_CTRL_PERF_CNT_EN is defined.
module cpu_ctrl_fsm #(
    parameter int                 OP_BITS = 5,
    parameter logic [OP_BITS-1:0] HALT_OP = 5'b11100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [OP_BITS-1:0] dec_op,
    input  logic               dec_mem_rd,
    input  logic               dec_mem_wr,
    input  logic               dec_reg_wr,
    input  logic               dec_cond_update,
    input  logic               branch_taken,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_en,
    output logic               alu_en,
    output logic               flags_we,
    output logic               rf_we,
    output logic               wb_sel,
    output logic               pc_en,
    output logic               pc_sel,
    output logic               retire,
    output logic               halted,
    output logic [2:0]         state,
    output logic [31:0]        retired_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire_d;

    logic   mem_req_q;
    logic   addr_sel_q;
    logic   alu_en_q;
    logic   rf_we_q;
    logic   halted_q;

    // Next-state decode; run is only consulted at instruction boundaries and in IDLE/HALT.
    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = (dec_op == HALT_OP) ? HALT : EXEC;
            end
            EXEC: begin
                if (dec_mem_rd || dec_mem_wr) begin
                    state_d = MEM;
                end else if (dec_reg_wr) begin
                    state_d = WB;
                end else begin
                    retire_d = 1'b1;
                    state_d  = run ? FETCH : IDLE;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    if (dec_mem_rd) begin
                        state_d = WB;
                    end else begin
                        retire_d = 1'b1;
                        state_d  = run ? FETCH : IDLE;
                    end
                end
            end
            WB: begin
                retire_d = 1'b1;
                state_d  = run ? FETCH : IDLE;
            end
            HALT: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            addr_sel_q <= 1'b0;
            alu_en_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= (state_d == FETCH) || (state_d == MEM);
            addr_sel_q <= (state_d == MEM);
            alu_en_q   <= (state_d == EXEC);
            rf_we_q    <= (state_d == WB);
            halted_q   <= (state_d == HALT);
        end
    end

    // A reset cycle aborts the instruction, so it must not also report a retirement.
    assign retire   = retire_d & rst_n;
    assign pc_en    = retire;
    assign pc_sel   = retire & branch_taken;

    assign mem_req  = mem_req_q;
    assign addr_sel = addr_sel_q;
    assign mem_we   = addr_sel_q & dec_mem_wr & ~dec_mem_rd;
    assign ir_en    = mem_req_q & ~addr_sel_q & mem_ack;
    assign alu_en   = alu_en_q;
    assign flags_we = alu_en_q & dec_cond_update;
    assign rf_we    = rf_we_q;
    assign wb_sel   = rf_we_q & dec_mem_rd;
    assign halted   = halted_q;
    assign state    = state_q;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt_q;

    // Free-running retirement count; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
        end else if (retire) begin
            retired_cnt_q <= retired_cnt_q + 32'd1;
        end
    end

    assign retired_cnt = retired_cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: instructions are expanded into per-cycle expected
// phase schedules (fetch/decode/exec/mem/wb) with randomized wait states and run drops.
module tb_cpu_ctrl_fsm;

    localparam logic [4:0] HALT_OP = 5'b11100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [4:0]  dec_op;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_reg_wr;
    logic        dec_cond_update;
    logic        branch_taken;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_en;
    logic        alu_en;
    logic        flags_we;
    logic        rf_we;
    logic        wb_sel;
    logic        pc_en;
    logic        pc_sel;
    logic        retire;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] retired_cnt;

    always #5 clk = ~clk;

    cpu_ctrl_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .dec_op          (dec_op),
        .dec_mem_rd      (dec_mem_rd),
        .dec_mem_wr      (dec_mem_wr),
        .dec_reg_wr      (dec_reg_wr),
        .dec_cond_update (dec_cond_update),
        .branch_taken    (branch_taken),
        .mem_ack         (mem_ack),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .addr_sel        (addr_sel),
        .ir_en           (ir_en),
        .alu_en          (alu_en),
        .flags_we        (flags_we),
        .rf_we           (rf_we),
        .wb_sel          (wb_sel),
        .pc_en           (pc_en),
        .pc_sel          (pc_sel),
        .retire          (retire),
        .halted          (halted),
        .state           (state),
        .retired_cnt     (retired_cnt)
    );

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic       iren;
        logic       alu;
        logic       flw;
        logic       rfw;
        logic       wbs;
        logic       pcen;
        logic       pcsel;
        logic       ret;
        logic       hlt;
        logic [2:0] st;
    } outT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelCnt = '0;

    // Compares every control output plus the retirement counter against the schedule.
    task automatic checkOutput(input outT e, input string tag);
        outT         obs;
        logic [31:0] expCnt;
        obs = {mem_req, mem_we, addr_sel, ir_en, alu_en, flags_we, rf_we, wb_sel,
               pc_en, pc_sel, retire, halted, state};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: got %b expected %b", tag, obs, e);
        end
`ifdef CPU_CTRL_PERF_CNT_EN
        expCnt = modelCnt;
`else
        expCnt = '0;
`endif
        checks++;
        assert (retired_cnt === expCnt) else begin
            errors++;
            $error("[TB] FAIL %s retired_cnt: got %0d expected %0d", tag, retired_cnt, expCnt);
        end
    endtask

    // Drives one cycle of inputs, checks mid-cycle, then advances past the rising edge.
    task automatic applyStimulus(input logic rstV, input logic runV, input logic ackV,
                                 input outT e, input string tag);
        logic br;
        br           = 1'($urandom_range(0, 1));
        rst_n        = rstV;
        run          = runV;
        mem_ack      = ackV;
        branch_taken = br;
        if (e.ret) e.pcsel = br;
        #3;
        checkOutput(e, tag);
        @(posedge clk);
        #1;
        if (!rstV) modelCnt = '0;
        else if (e.ret) modelCnt = modelCnt + 32'd1;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, (i == n - 1), 1'($urandom_range(0, 1)), '0, tag);
        end
    endtask

    // kind: 0 ALU, 1 ALU+writeback, 2 load, 3 store. Entered with the DUT about to be in FETCH.
    task automatic runInstr(input int kind, input int fw, input int mw, input logic runAfter,
                            input logic abortInMem, input string tag);
        outT  e;
        logic rd;
        logic wr;
        logic ack;
        rd              = (kind == 2);
        wr              = (kind == 3);
        dec_op          = 5'($urandom_range(0, 27));
        dec_mem_rd      = rd;
        dec_mem_wr      = wr;
        dec_reg_wr      = (kind == 1 || kind == 2) ? 1'b1 :
                          (kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        dec_cond_update = 1'($urandom_range(0, 1));

        for (int i = 0; i <= fw; i++) begin
            e = '0; e.req = 1'b1; e.st = 3'd1; e.iren = (i == fw);
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), (i == fw), e, {tag, "/fetch"});
        end

        e = '0; e.st = 3'd2;
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, {tag, "/decode"});

        e = '0; e.alu = 1'b1; e.flw = dec_cond_update; e.st = 3'd3;
        if (kind == 0) begin
            e.ret = 1'b1; e.pcen = 1'b1;
            applyStimulus(1'b1, runAfter, 1'($urandom_range(0, 1)), e, {tag, "/exec"});
        end else begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, {tag, "/exec"});
        end

        if (rd || wr) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.req = 1'b1; e.asel = 1'b1; e.we = wr; e.st = 3'd4;
                if (abortInMem) begin
                    applyStimulus(1'b0, 1'b1, 1'b0, e, {tag, "/mem_rst"});
                    applyStimulus(1'b0, 1'b1, 1'b1, '0, {tag, "/in_reset"});
                    applyStimulus(1'b1, 1'b1, 1'b1, '0, {tag, "/idle"});
                    return;
                end
                ack = (i == mw);
                if (ack && wr) begin
                    e.ret = 1'b1; e.pcen = 1'b1;
                    applyStimulus(1'b1, runAfter, ack, e, {tag, "/mem"});
                end else begin
                    applyStimulus(1'b1, 1'($urandom_range(0, 1)), ack, e, {tag, "/mem"});
                end
            end
        end

        if (kind == 1 || kind == 2) begin
            e = '0; e.rfw = 1'b1; e.wbs = rd; e.st = 3'd5; e.ret = 1'b1; e.pcen = 1'b1;
            applyStimulus(1'b1, runAfter, 1'($urandom_range(0, 1)), e, {tag, "/wb"});
        end

        if (!runAfter) idleCycles($urandom_range(1, 3), {tag, "/idle"});
    endtask

    // HALT instruction: never retires, holds while run=1, leaves to IDLE on run=0.
    task automatic runHalt(input int fw, input int hold, input string tag);
        outT e;
        dec_op          = HALT_OP;
        dec_mem_rd      = 1'b0;
        dec_mem_wr      = 1'b0;
        dec_reg_wr      = 1'($urandom_range(0, 1));
        dec_cond_update = 1'($urandom_range(0, 1));
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.req = 1'b1; e.st = 3'd1; e.iren = (i == fw);
            applyStimulus(1'b1, 1'b1, (i == fw), e, {tag, "/fetch"});
        end
        e = '0; e.st = 3'd2;
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, {tag, "/decode"});
        for (int i = 0; i <= hold; i++) begin
            e = '0; e.hlt = 1'b1; e.st = 3'd6;
            applyStimulus(1'b1, (i != hold), 1'($urandom_range(0, 1)), e, {tag, "/halt"});
        end
        idleCycles(1, {tag, "/idle"});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] tenExp;
        rst_n           = 1'b0;
        run             = 1'b1;
        mem_ack         = 1'b1;
        branch_taken    = 1'b0;
        dec_op          = '0;
        dec_mem_rd      = 1'b0;
        dec_mem_wr      = 1'b0;
        dec_reg_wr      = 1'b0;
        dec_cond_update = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1, '0, "reset");
        applyStimulus(1'b0, 1'b1, 1'b1, '0, "reset");
        applyStimulus(1'b1, 1'b1, 1'b1, '0, "idle_start");

        runInstr(0, 0, 0, 1'b1, 1'b0, "alu");
        runInstr(1, 0, 0, 1'b1, 1'b0, "alu_wb");
        runInstr(2, 0, 2, 1'b1, 1'b0, "load_wait2");
        runInstr(3, 1, 0, 1'b1, 1'b0, "store_fwait");
        runHalt(0, 2, "halt");
        runInstr(2, 0, 3, 1'b1, 1'b1, "abort_mem");

        for (int i = 0; i < 10; i++) begin
            runInstr($urandom_range(0, 3), 0, 0, (i != 9), 1'b0, "ten");
        end
`ifdef CPU_CTRL_PERF_CNT_EN
        tenExp = 32'd10;
`else
        tenExp = 32'd0;
`endif
        checks++;
        assert (retired_cnt === tenExp) else begin
            errors++;
            $error("[TB] FAIL ten_count: got %0d expected %0d", retired_cnt, tenExp);
        end

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                runHalt($urandom_range(0, 2), $urandom_range(0, 2), "rand_halt");
            end else begin
                runInstr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                         ($urandom_range(0, 4) != 0), 1'b0, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
